prefetch_buffer: RTL and testbench

Instruction prefetch buffer that sits directly upstream of `fetch_stage`, between the instruction memory port and the fetch logic. It issues sequential word fetches to instruction memory, buffers in-order responses in a small FIFO, and presents them with their addresses to the fetch stage through a valid/ready handshake. A redirect (`target_valid_i`) flushes the buffer, discards in-flight responses, and restarts fetching at the new target.

---
 rtl/prefetch_buffer.sv | 139 +++++++++++++
 tb/tb_prefetch_buffer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: sequential word fetch into an in-order FIFO,
// with redirect flush and discard of in-flight stale responses.
module prefetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [31:0] target_addr_i,
  input  logic        target_valid_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_addr, fetch_addr_n;
  logic [ADDR_W-1:0]   resp_addr, resp_addr_n;
  logic [CNT_W-1:0]    outstanding, outstanding_n;
  logic [CNT_W-1:0]    discard, discard_n;
  logic [CNT_W-1:0]    count, count_n, idle_count;
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [WORD_W-1:0]   data_q [DEPTH];
  logic                stale, stale_n;
  logic [ADDR_W-1:0]   target;
  logic                grant, stale_grant, live_grant;
  logic                drop, push, pop;
  logic                issue_idle, issue_next;

  assign instr_valid_o = (count != '0);
  assign instr_o       = data_q[rd_ptr];
  assign instr_addr_o  = addr_q[rd_ptr];

  always_comb begin
    target        = {target_addr_i[31:2], 2'b00};
    grant         = mem_req_o & mem_gnt_i;
    stale_grant   = grant & stale;
    live_grant    = grant & ~stale;
    drop          = mem_rvalid_i & (discard != '0);
    push          = mem_rvalid_i & (discard == '0) & ~target_valid_i;
    pop           = instr_valid_o & instr_ready_i & ~target_valid_i;
    outstanding_n = outstanding + CNT_W'(grant) - CNT_W'(mem_rvalid_i);
    if (target_valid_i) begin
      // Everything still in flight after this cycle belongs to the old stream,
      // and a request held ungranted keeps its old address, so tag it stale.
      count_n      = '0;
      discard_n    = outstanding_n;
      fetch_addr_n = target;
      resp_addr_n  = target;
      stale_n      = mem_req_o & ~mem_gnt_i;
    end else begin
      count_n      = count + CNT_W'(push) - CNT_W'(pop);
      discard_n    = discard - CNT_W'(drop) + CNT_W'(stale_grant);
      fetch_addr_n = live_grant ? fetch_addr + 32'd4 : fetch_addr;
      resp_addr_n  = push ? resp_addr + 32'd4 : resp_addr;
      stale_n      = stale & ~grant;
    end
    idle_count = target_valid_i ? '0 : count;
    issue_idle = req_i & ((SUM_W'(idle_count) + SUM_W'(outstanding)) < DEPTH_S);
    issue_next = req_i & ((SUM_W'(count_n) + SUM_W'(outstanding_n)) < DEPTH_S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= BOOT_ADDR;
      fetch_addr  <= BOOT_ADDR;
      resp_addr   <= BOOT_ADDR;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      stale       <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      outstanding <= outstanding_n;
      discard     <= discard_n;
      count       <= count_n;
      fetch_addr  <= fetch_addr_n;
      resp_addr   <= resp_addr_n;
      stale       <= stale_n;
      if (target_valid_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          addr_q[wr_ptr] <= resp_addr;
          data_q[wr_ptr] <= mem_rdata_i;
          wr_ptr         <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // The request is only allowed to move or drop once granted.
      case (state)
        IDLE: begin
          if (issue_idle) begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= fetch_addr_n;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            if (issue_next) begin
              mem_addr_o <= fetch_addr_n;
            end else begin
              state     <= IDLE;
              mem_req_o <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: transaction-level model of the memory and of the
// expected instruction stream, driven by directed steps and random traffic.
module tb_prefetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] target_addr_i = '0;
  logic        target_valid_i = 1'b0;
  logic [31:0] instr_o, instr_addr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  prefetch_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i),
    .target_addr_i(target_addr_i), .target_valid_i(target_valid_i),
    .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Memory keeps the address it was granted; the model keeps the address the
  // stream should have had, plus the redirect epoch the request belongs to.
  typedef struct { logic [31:0] bus; logic [31:0] exp; int unsigned tag; } mreq_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

  mreq_t       memq[$];
  ent_t        fq[$];
  int unsigned epoch = 0, cur_tag = 0;
  logic [31:0] next_req = BOOT;
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, grants = 0, pops = 0;
  int          k_req = 0, k_ready = 0, k_gnt = 0, k_rv = 0;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + 32'h0001_1111;
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    fq.delete();
    epoch++;
    cur_tag  = epoch;
    next_req = BOOT;
    prev_req = 1'b0;
    prev_gnt = 1'b0;
  endtask

  task automatic drive(input bit req, input bit ready, input bit gnt, input bit rv,
                       input bit redir, input logic [31:0] tgt);
    req_i          = req;
    instr_ready_i  = ready;
    mem_gnt_i      = gnt;
    target_valid_i = redir;
    target_addr_i  = redir ? tgt : $urandom();
    if (rv && memq.size() != 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = fdata(memq[0].bus);
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom();
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    #1;
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_instr_addr", instr_addr_o, 32'h0);
    check("rst_mem_addr", mem_addr_o, BOOT);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    logic        g, rv, rd, pop, np, pre_req, pre_req_i;
    logic [31:0] a, tgt;
    mreq_t       r;
    g         = mem_req_o & mem_gnt_i;
    rv        = mem_rvalid_i;
    rd        = target_valid_i;
    tgt       = {target_addr_i[31:2], 2'b00};
    a         = mem_addr_o;
    pre_req   = mem_req_o;
    pre_req_i = req_i;
    np        = mem_req_o && (!prev_req || prev_gnt);
    if (np) cur_tag = epoch;
    pop = (fq.size() != 0) && instr_ready_i && !rd;
    if (g && cur_tag == epoch) check("req_addr", a, next_req);
    @(posedge clk);
    #1;
    cyc++;
    if (pop) begin
      void'(fq.pop_front());
      pops++;
    end
    if (rv) begin
      r = memq.pop_front();
      if (r.tag == epoch) fq.push_back('{r.exp, fdata(r.exp)});
    end
    if (g) begin
      memq.push_back('{a, next_req, cur_tag});
      grants++;
      if (cur_tag == epoch) next_req += 32'd4;
    end
    if (rd) begin
      fq.delete();
      epoch++;
      next_req = tgt;
    end
    check("instr_valid", 32'(instr_valid_o), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      check("instr_addr", instr_addr_o, fq[0].addr);
      check("instr_data", instr_o, fq[0].data);
    end
    check("occupancy", 32'((memq.size() + fq.size()) <= int'(DEPTH)), 32'd1);
    if (pre_req && !g) begin
      check("req_hold", 32'(mem_req_o), 32'd1);
      check("addr_hold", mem_addr_o, a);
    end
    if (mem_req_o && !pre_req) check("req_rise_needs_req_i", 32'(pre_req_i), 32'd1);
    prev_req = pre_req;
    prev_gnt = g;
  endtask

  task automatic cycle_k(input bit redir, input logic [31:0] tgt);
    drive(pct(k_req), pct(k_ready), pct(k_gnt), pct(k_rv), redir, tgt);
    step();
  endtask

  task automatic knobs(input int rq, input int rdy, input int gn, input int rv);
    k_req = rq; k_ready = rdy; k_gnt = gn; k_rv = rv;
  endtask

  task automatic wait_req(input int limit, input string tag);
    for (int i = 0; i < limit && !mem_req_o; i++) cycle_k(0, 32'h0);
    check(tag, 32'(mem_req_o), 32'd1);
  endtask

  task automatic wait_valid(input int limit, input string tag, input logic [31:0] addr);
    for (int i = 0; i < limit && !instr_valid_o; i++) cycle_k(0, 32'h0);
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
    check(tag, instr_addr_o, addr);
  endtask

  initial begin
    int first_req, first_valid, g0, p0;

    // Reset, then a full-rate sequential stream.
    do_reset();
    knobs(100, 100, 100, 100);
    first_req = -1;
    first_valid = -1;
    p0 = pops;
    for (int i = 0; i < 12; i++) begin
      cycle_k(0, 32'h0);
      if (mem_req_o && first_req < 0) first_req = cyc;
      if (instr_valid_o && first_valid < 0) first_valid = cyc;
    end
    check("first_valid_latency", 32'(first_valid - first_req), 32'd2);
    check("stream_pops", 32'(pops - p0), 32'd9);

    // Backpressure: the window closes after DEPTH grants.
    do_reset();
    knobs(100, 0, 100, 100);
    g0 = grants;
    repeat (10) cycle_k(0, 32'h0);
    check("bp_grants", 32'(grants - g0), 32'(DEPTH));
    check("bp_req_low", 32'(mem_req_o), 32'd0);
    knobs(100, 100, 100, 100);
    p0 = pops;
    wait_req(8, "bp_resume_req");
    check("bp_resume_addr", mem_addr_o, 32'h10);
    repeat (6) cycle_k(0, 32'h0);
    check("bp_drain", 32'((pops - p0) >= 4), 32'd1);

    // Redirect with responses in flight.
    do_reset();
    knobs(100, 100, 100, 0);
    repeat (3) cycle_k(0, 32'h0);
    knobs(100, 100, 0, 100);
    cycle_k(1, 32'h2000);
    check("redir_valid_drop", 32'(instr_valid_o), 32'd0);
    knobs(100, 100, 100, 100);
    wait_valid(20, "redir_first", 32'h2000);

    // Redirect while a request waits for its grant.
    do_reset();
    knobs(0, 100, 0, 100);
    cycle_k(1, 32'h40);
    knobs(100, 100, 0, 100);
    wait_req(5, "stale_req");
    check("stale_addr", mem_addr_o, 32'h40);
    cycle_k(0, 32'h0);
    cycle_k(1, 32'h103);
    cycle_k(0, 32'h0);
    check("stale_hold", mem_addr_o, 32'h40);
    knobs(100, 100, 100, 100);
    cycle_k(0, 32'h0);
    check("target_req", 32'(mem_req_o), 32'd1);
    check("target_addr", mem_addr_o, 32'h100);
    wait_valid(20, "target_first", 32'h100);

    // Address wrap.
    do_reset();
    knobs(0, 100, 100, 100);
    cycle_k(1, 32'hFFFF_FFF8);
    knobs(100, 100, 100, 100);
    wait_valid(20, "wrap_0", 32'hFFFF_FFF8);
    cycle_k(0, 32'h0);
    check("wrap_1", instr_addr_o, 32'hFFFF_FFFC);
    cycle_k(0, 32'h0);
    check("wrap_2", instr_addr_o, 32'h0000_0000);

    // Pop, push, grant and redirect in one cycle.
    do_reset();
    knobs(100, 100, 100, 100);
    repeat (5) cycle_k(0, 32'h0);
    check("simul_setup", 32'(instr_valid_o), 32'd1);
    cycle_k(1, 32'h3000);
    check("simul_empty", 32'(instr_valid_o), 32'd0);
    wait_valid(20, "simul_first", 32'h3000);

    // Random traffic with redirects and occasional reset.
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      knobs(90, 70, 60, 50);
      if ($urandom_range(999) < 2) do_reset();
      cycle_k(pct(3), $urandom());
    end
    check("random_progress", 32'((pops - p0) > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
